// File: rtl/bcd_time_counter.sv
// Two-digit BCD time counter stage with carry-in, button setting and parallel load.
// Value is kept as BCD digits; carry_out pulses when run-mode counting wraps.
module bcd_time_counter #(
    parameter int MOD  = 60,
    parameter int INIT = 0
) (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic       cnt_en,
    input  logic       set_mode,
    input  logic       set_up,
    input  logic       set_dn,
    input  logic       load_en,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out,
    output logic       at_max,
    output logic       load_err
);

    localparam logic [3:0] MAX_T    = 4'((MOD - 1) / 10);
    localparam logic [3:0] MAX_O    = 4'((MOD - 1) % 10);
    localparam logic [3:0] INIT_T   = 4'(INIT / 10);
    localparam logic [3:0] INIT_O   = 4'(INIT % 10);
    localparam logic       INIT_MAX = (INIT == MOD - 1);
    localparam logic [7:0] MOD_B    = 8'(MOD);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       carry_q, carry_d;
    logic       at_max_q, at_max_d;
    logic       load_err_q, load_err_d;
    logic       up_prev_q, up_prev_d;
    logic       dn_prev_q, dn_prev_d;

    logic       cur_max;
    logic       cur_zero;
    logic       up_rise;
    logic       dn_rise;
    logic       load_ok;
    logic [7:0] load_bin;
    logic [3:0] inc_t, inc_o;
    logic [3:0] dec_t, dec_o;

    assign cur_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign cur_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign up_rise  = set_up & ~up_prev_q;
    assign dn_rise  = set_dn & ~dn_prev_q;

    // 8 bits: invalid digits up to 15 can give values beyond 127
    assign load_bin = {4'd0, load_tens} * 8'd10 + {4'd0, load_ones};
    assign load_ok  = (load_tens <= 4'd9) && (load_ones <= 4'd9)
                   && (load_bin < MOD_B);

    always_comb begin
        inc_t = tens_q;
        inc_o = ones_q + 4'd1;
        if (cur_max) begin
            inc_t = 4'd0;
            inc_o = 4'd0;
        end else if (ones_q == 4'd9) begin
            inc_t = tens_q + 4'd1;
            inc_o = 4'd0;
        end
    end

    always_comb begin
        dec_t = tens_q;
        dec_o = ones_q - 4'd1;
        if (cur_zero) begin
            dec_t = MAX_T;
            dec_o = MAX_O;
        end else if (ones_q == 4'd0) begin
            dec_t = tens_q - 4'd1;
            dec_o = 4'd9;
        end
    end

    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        up_prev_d  = set_up;
        dn_prev_d  = set_dn;
        if (load_en) begin
            if (load_ok) begin
                tens_d = load_tens;
                ones_d = load_ones;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (set_mode) begin
            if (up_rise && !dn_rise) begin
                tens_d = inc_t;
                ones_d = inc_o;
            end else if (dn_rise && !up_rise) begin
                tens_d = dec_t;
                ones_d = dec_o;
            end
        end else if (cnt_en) begin
            tens_d  = inc_t;
            ones_d  = inc_o;
            carry_d = cur_max;
        end
        at_max_d = (tens_d == MAX_T) && (ones_d == MAX_O);
    end

    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            tens_q     <= INIT_T;
            ones_q     <= INIT_O;
            carry_q    <= 1'b0;
            at_max_q   <= INIT_MAX;
            load_err_q <= 1'b0;
            up_prev_q  <= 1'b0;
            dn_prev_q  <= 1'b0;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            at_max_q   <= at_max_d;
            load_err_q <= load_err_d;
            up_prev_q  <= up_prev_d;
            dn_prev_q  <= dn_prev_d;
        end
    end

    assign tens      = tens_q;
    assign ones      = ones_q;
    assign carry_out = carry_q;
    assign at_max    = at_max_q;
    assign load_err  = load_err_q;

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 The block SHALL take parameter MOD, default 60: modulus of the two-digit BCD count; legal range 2..99.
REQ-002 The block SHALL take parameter INIT, default 0: binary value loaded on reset; legal range 0..MOD-1.
REQ-003 The block SHALL have input clk, 1 bit: the single rising-edge clock for all state.
REQ-004 The block SHALL have input CLR_n, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have input cnt_en, 1 bit: one-cycle carry-in pulse from the lower-order stage; counts up by one.
REQ-006 The block SHALL have input set_mode, 1 bit: level; high selects time-setting mode.
REQ-007 The block SHALL have input set_up, 1 bit: level from the up button, already synchronised to clk.
REQ-008 The block SHALL have input set_dn, 1 bit: level from the down button, already synchronised to clk.
REQ-009 The block SHALL have input load_en, 1 bit: one-cycle parallel load strobe.
REQ-010 The block SHALL have input load_tens, 4 bits: BCD tens digit to load.
REQ-011 The block SHALL have input load_ones, 4 bits: BCD ones digit to load.
REQ-012 The block SHALL have output tens, 4 bits: registered BCD tens digit.
REQ-013 The block SHALL have output ones, 4 bits: registered BCD ones digit.
REQ-014 The block SHALL have output carry_out, 1 bit: registered one-cycle pulse on a run-mode wrap.
REQ-015 The block SHALL have output at_max, 1 bit: registered flag, high while the value equals MOD-1.
REQ-016 The block SHALL have output load_err, 1 bit: registered one-cycle pulse when a load is rejected.

Function
REQ-017 Value V SHALL equal 10*tens + ones; ones is always 0..9 and V is always 0..MOD-1.
REQ-018 Each clk edge SHALL apply exactly one action, in this priority: load, set, count, hold.
REQ-019 Load: if load_en=1 and both digits are <=9 and V_new < MOD, V SHALL take the loaded value; otherwise V holds and load_err pulses for one cycle.
REQ-020 Set: when set_mode=1, a rising edge detected on set_up (previous sample 0, current sample 1) SHALL increment V.
REQ-021 Set: the increment of REQ-020 SHALL wrap MOD-1 -> 0 without asserting carry_out.
REQ-022 Set: a rising edge detected on set_dn SHALL decrement V, wrapping 0 -> MOD-1 without a carry or borrow output.
REQ-023 If set_up and set_dn rising edges occur on the same cycle, V SHALL hold.
REQ-024 Held button levels SHALL produce only one step per press; there is no auto-repeat.
REQ-025 While set_mode=1, cnt_en SHALL be ignored; carry-in pulses arriving in this mode are lost, not queued.
REQ-026 Count: when set_mode=0 and cnt_en=1, V SHALL increment. The ones digit wraps 9 -> 0 with tens+1.
REQ-027 Count: when V=MOD-1, the increment of REQ-026 SHALL set V to 0 and assert carry_out on that same edge for exactly one cycle.
REQ-028 carry_out SHALL be 0 on every edge that does not perform a run-mode wrap; cnt_en held high for N cycles SHALL yield N increments.
REQ-029 at_max SHALL be recomputed from the next-state value, so it is valid in the same cycle as tens and ones, with no extra latency.
REQ-030 The button edge detectors SHALL sample set_up and set_dn every cycle regardless of set_mode. A press made before set_mode rises SHALL NOT be acted on later.
REQ-031 A load during set_mode=1 SHALL take priority and SHALL clear any pending same-cycle set step.
REQ-032 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-033 While CLR_n=1, asynchronously: tens/ones SHALL equal INIT in BCD, carry_out=0, load_err=0, at_max=(INIT==MOD-1), and edge-detector history=0.
REQ-034 Reset asserted mid-operation SHALL override any action in flight; the first action SHALL occur on the first clk edge after CLR_n falls.

Verification
REQ-035 Bench: MOD=60, V=58, set_mode=0, cnt_en pulsed twice -> V=59 with at_max=1, then V=00 with carry_out=1 for exactly one cycle.
REQ-036 Bench: MOD=24, V=00, set_mode=1, one set_dn press -> V=23, carry_out stays 0; then one set_up press -> V=00.
REQ-037 Bench: set_mode=1, set_up held high 10 cycles while cnt_en pulses every cycle -> V advances by exactly 1, carry_out=0 throughout.
REQ-038 Bench: MOD=60, load 5/9 -> V=59 and at_max=1; load 6/0 -> V unchanged and load_err pulses; load 1/A -> rejected.
REQ-039 Bench: CLR_n asserted between clk edges with V=37 -> outputs go to INIT immediately with no clk edge; carry_out=0.
REQ-040 Bench: set_up and set_dn rising together, and load_en with cnt_en in the same cycle -> hold in the first case and load wins in the second, with no carry_out.
